// File: rtl/eerrl_pkg.sv
// Shared EER-RL node definitions: field widths, sentinel values and the
// cluster-head advertisement sequencer state type.
package eerrl_pkg;

    localparam int          WORD_WIDTH   = 16;
    localparam logic [15:0] HOPS_INVALID = 16'hFFFF;
    localparam logic [15:0] Q_ONE        = 16'h4000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HBRST,
        ST_COLLECT,
        ST_ISSUE,
        ST_SETTLE,
        ST_DONE
    } ch_seq_state_t;

endpackage

// File: rtl/ch_window_timer.sv
// Round window timer: holds the latched window length and a saturating cycle
// counter; expire is asserted from the cycle where count+1 reaches the window.
module ch_window_timer #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_value,
    input  logic                  clear,
    input  logic                  enable,
    output logic                  expire,
    output logic                  window_zero
);

    logic [WORD_WIDTH-1:0] window;
    logic [WORD_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            window <= '0;
            count  <= '0;
        end else begin
            if (load) begin
                window <= load_value;
            end
            if (clear) begin
                count <= '0;
            end else if (enable && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

    // Extra bit keeps count+1 from wrapping once the counter has saturated,
    // which also makes expire sticky for the rest of the round.
    assign window_zero = (window == '0);
    assign expire      = !window_zero && (({1'b0, count} + 1'b1) >= {1'b0, window});

endmodule

// File: rtl/ch_adv_sequencer.sv
// Round sequencer in front of the knownCH selector: clears it on a heartbeat,
// filters cluster-head advertisements and forwards each kept one as a strobe.
module ch_adv_sequencer #(
    parameter int WORD_WIDTH = eerrl_pkg::WORD_WIDTH,
    parameter int SETTLE     = 2,
    parameter int HB_RST_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] my_nodeID,
    input  logic                  hb_start,
    input  logic [WORD_WIDTH-1:0] hb_chlimit,
    input  logic [WORD_WIDTH-1:0] hb_window,
    input  logic                  adv_valid,
    output logic                  adv_ready,
    input  logic [WORD_WIDTH-1:0] adv_ID,
    input  logic [WORD_WIDTH-1:0] adv_Hops,
    input  logic [WORD_WIDTH-1:0] adv_QValue,
    output logic                  HB_reset,
    output logic                  en_KCH,
    output logic [WORD_WIDTH-1:0] fCH_ID,
    output logic [WORD_WIDTH-1:0] fCH_Hops,
    output logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic                  round_active,
    output logic                  round_done,
    output logic [WORD_WIDTH-1:0] ch_count,
    output logic [WORD_WIDTH-1:0] drop_count
);

    import eerrl_pkg::*;

    localparam int             HBW     = (HB_RST_CYC > 1) ? $clog2(HB_RST_CYC) : 1;
    localparam int             STW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [HBW-1:0] HB_LAST = HBW'(HB_RST_CYC - 1);
    localparam logic [STW-1:0] ST_LAST = STW'(SETTLE - 1);

    ch_seq_state_t         state;
    ch_seq_state_t         state_nxt;
    logic [HBW-1:0]        hb_cnt;
    logic [STW-1:0]        settle_cnt;
    logic [WORD_WIDTH-1:0] limit_lat;
    logic                  expire;
    logic                  window_zero;
    logic                  handshake;
    logic                  drop;
    logic                  limit_hit;
    logic                  closing;
    logic                  timer_run;
    logic                  timer_clear;

    assign handshake   = adv_valid && adv_ready;
    assign drop        = (adv_ID == my_nodeID) || (adv_Hops == {WORD_WIDTH{1'b1}});
    assign limit_hit   = (limit_lat != '0) && (ch_count == limit_lat);
    assign closing     = expire || limit_hit;
    assign timer_run   = (state == ST_COLLECT) || (state == ST_ISSUE) || (state == ST_SETTLE);
    assign timer_clear = hb_start || (state == ST_HBRST);

    ch_window_timer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (hb_start),
        .load_value  (hb_window),
        .clear       (timer_clear),
        .enable      (timer_run),
        .expire      (expire),
        .window_zero (window_zero)
    );

    // A heartbeat in any state restarts the round; a forwarded advertisement
    // takes priority over closure so an accepted update is never lost.
    always_comb begin
        state_nxt = state;
        if (hb_start) begin
            state_nxt = ST_HBRST;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_IDLE;
                ST_HBRST: begin
                    if (hb_cnt == HB_LAST) begin
                        state_nxt = ((limit_lat == '0) && window_zero) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (handshake && !drop) begin
                        state_nxt = ST_ISSUE;
                    end else if (closing) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_ISSUE:   state_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    if (settle_cnt == ST_LAST) begin
                        state_nxt = closing ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_DONE:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hb_cnt       <= '0;
            settle_cnt   <= '0;
            limit_lat    <= '0;
            HB_reset     <= 1'b0;
            adv_ready    <= 1'b0;
            en_KCH       <= 1'b0;
            round_active <= 1'b0;
            round_done   <= 1'b0;
            ch_count     <= '0;
            drop_count   <= '0;
            fCH_ID       <= '0;
            fCH_Hops     <= '1;
            fCH_QValue   <= '0;
        end else begin
            state        <= state_nxt;
            HB_reset     <= (state_nxt == ST_HBRST);
            adv_ready    <= (state_nxt == ST_COLLECT);
            en_KCH       <= (state_nxt == ST_ISSUE);
            round_done   <= (state_nxt == ST_DONE);
            round_active <= (state_nxt != ST_IDLE);

            if (hb_start) begin
                hb_cnt <= '0;
            end else if (state == ST_HBRST) begin
                hb_cnt <= hb_cnt + 1'b1;
            end

            if (state == ST_ISSUE) begin
                settle_cnt <= '0;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            if (hb_start) begin
                ch_count   <= '0;
                drop_count <= '0;
                limit_lat  <= hb_chlimit;
            end else if ((state == ST_COLLECT) && handshake) begin
                if (drop) begin
                    if (drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
                end else begin
                    ch_count   <= ch_count + 1'b1;
                    fCH_ID     <= adv_ID;
                    fCH_Hops   <= adv_Hops;
                    fCH_QValue <= adv_QValue;
                end
            end
        end
    end

endmodule

// File: tb/tb_ch_adv_sequencer.sv
// Directed bench for ch_adv_sequencer with a cycle-timeline reference model
// compared every cycle, plus literal expectations at key points.
module tb_ch_adv_sequencer;

    localparam int W   = 16;
    localparam int ST  = 2;
    localparam int HBR = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] my_nodeID;
    logic         hb_start;
    logic [W-1:0] hb_chlimit;
    logic [W-1:0] hb_window;
    logic         adv_valid;
    logic         adv_ready;
    logic [W-1:0] adv_ID;
    logic [W-1:0] adv_Hops;
    logic [W-1:0] adv_QValue;
    logic         HB_reset;
    logic         en_KCH;
    logic [W-1:0] fCH_ID;
    logic [W-1:0] fCH_Hops;
    logic [W-1:0] fCH_QValue;
    logic         round_active;
    logic         round_done;
    logic [W-1:0] ch_count;
    logic [W-1:0] drop_count;

    always #5 clk = ~clk;

    ch_adv_sequencer #(
        .WORD_WIDTH (W),
        .SETTLE     (ST),
        .HB_RST_CYC (HBR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .my_nodeID    (my_nodeID),
        .hb_start     (hb_start),
        .hb_chlimit   (hb_chlimit),
        .hb_window    (hb_window),
        .adv_valid    (adv_valid),
        .adv_ready    (adv_ready),
        .adv_ID       (adv_ID),
        .adv_Hops     (adv_Hops),
        .adv_QValue   (adv_QValue),
        .HB_reset     (HB_reset),
        .en_KCH       (en_KCH),
        .fCH_ID       (fCH_ID),
        .fCH_Hops     (fCH_Hops),
        .fCH_QValue   (fCH_QValue),
        .round_active (round_active),
        .round_done   (round_done),
        .ch_count     (ch_count),
        .drop_count   (drop_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: outputs for the next cycle are derived from absolute
    // cycle numbers (heartbeat end, window start, settle end) and counts.
    bit           chk_en = 1'b0;
    bit           m_round = 1'b0;
    int           cyc = 0;
    int           m_hb_end = -10;
    int           m_wstart = 0;
    int           m_settle_end = -10;
    int           m_lim = 0;
    int           m_win = 0;
    logic         e_hbr, e_rdy, e_en, e_done, e_act;
    logic [W-1:0] e_cnt, e_drop, e_fid, e_fh, e_fq;

    function automatic bit m_closes(input int c);
        return ((m_win != 0) && (c >= m_wstart + m_win - 1)) ||
               ((m_lim != 0) && (int'(e_cnt) == m_lim));
    endfunction

    always @(negedge clk) begin
        bit cur_rdy;
        bit cur_done;
        if (chk_en) begin
            chk("HB_reset", HB_reset, e_hbr);
            chk("adv_ready", adv_ready, e_rdy);
            chk("en_KCH", en_KCH, e_en);
            chk("round_done", round_done, e_done);
            chk("round_active", round_active, e_act);
            chk("ch_count", ch_count, e_cnt);
            chk("drop_count", drop_count, e_drop);
            chk("fCH_ID", fCH_ID, e_fid);
            chk("fCH_Hops", fCH_Hops, e_fh);
            chk("fCH_QValue", fCH_QValue, e_fq);
        end
        if (rst) begin
            chk_en  = 1'b1;
            m_round = 1'b0;
            e_hbr = 0; e_rdy = 0; e_en = 0; e_done = 0; e_act = 0;
            e_cnt = 0; e_drop = 0; e_fid = 0; e_fh = 16'hFFFF; e_fq = 0;
        end else if (chk_en) begin
            cur_rdy  = e_rdy;
            cur_done = e_done;
            e_hbr = 0; e_rdy = 0; e_en = 0; e_done = 0;
            if (hb_start) begin
                m_round      = 1'b1;
                m_hb_end     = cyc + HBR;
                m_wstart     = cyc + HBR + 1;
                m_settle_end = -10;
                m_lim        = int'(hb_chlimit);
                m_win        = int'(hb_window);
                e_cnt        = 0;
                e_drop       = 0;
                e_hbr        = 1;
            end else if (m_round) begin
                if (cyc + 1 <= m_hb_end) begin
                    e_hbr = 1;
                end else if (cyc == m_hb_end) begin
                    if (m_lim == 0 && m_win == 0) e_done = 1;
                    else e_rdy = 1;
                end else if (cur_rdy) begin
                    if (adv_valid && ((adv_ID == my_nodeID) || (adv_Hops == 16'hFFFF))) begin
                        if (e_drop != 16'hFFFF) e_drop = e_drop + 1;
                        if (m_closes(cyc)) e_done = 1;
                        else e_rdy = 1;
                    end else if (adv_valid) begin
                        e_cnt = e_cnt + 1;
                        e_fid = adv_ID;
                        e_fh  = adv_Hops;
                        e_fq  = adv_QValue;
                        e_en  = 1;
                        m_settle_end = cyc + 1 + ST;
                    end else if (m_closes(cyc)) begin
                        e_done = 1;
                    end else begin
                        e_rdy = 1;
                    end
                end else if (cyc < m_settle_end) begin
                    e_rdy = 0;
                end else if (cyc == m_settle_end) begin
                    if (m_closes(cyc)) e_done = 1;
                    else e_rdy = 1;
                end else if (cur_done) begin
                    m_round = 1'b0;
                end
            end
            e_act = m_round;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [W-1:0] lim, input logic [W-1:0] win);
        hb_chlimit = lim;
        hb_window  = win;
        hb_start   = 1'b1;
        tick();
        hb_start   = 1'b0;
    endtask

    task automatic send_adv(input logic [W-1:0] id, input logic [W-1:0] h, input logic [W-1:0] q);
        int n = 0;
        adv_ID     = id;
        adv_Hops   = h;
        adv_QValue = q;
        adv_valid  = 1'b1;
        while (!adv_ready && n < 100) begin
            tick();
            n++;
        end
        if (!adv_ready) chk("adv_ready_wait", adv_ready, 1'b1);
        tick();
        adv_valid = 1'b0;
    endtask

    task automatic send_fwd(input logic [W-1:0] id, input logic [W-1:0] h, input logic [W-1:0] q);
        send_adv(id, h, q);
        chk("lit_en_pulse", en_KCH, 1'b1);
        chk("lit_fCH_ID", fCH_ID, id);
        chk("lit_fCH_Hops", fCH_Hops, h);
        chk("lit_fCH_QValue", fCH_QValue, q);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!round_done && n < 60) begin
            tick();
            n++;
        end
        chk("round_done_wait", round_done, 1'b1);
    endtask

    initial begin
        int n;
        rst = 1'b1; my_nodeID = 16'd99; hb_start = 1'b0; hb_chlimit = '0; hb_window = '0;
        adv_valid = 1'b0; adv_ID = '0; adv_Hops = '0; adv_QValue = '0;
        tick(); tick();
        rst = 1'b0;
        chk("lit_reset_fCH_Hops", fCH_Hops, 16'hFFFF);
        chk("lit_reset_ready", adv_ready, 1'b0);

        // Round with limit 3, no window
        start_round(16'd3, 16'd0);
        chk("lit_hbrst_c1", HB_reset, 1'b1);
        tick();
        chk("lit_hbrst_c2", HB_reset, 1'b1);
        tick();
        chk("lit_ready_c3", adv_ready, 1'b1);
        chk("lit_hbrst_off_c3", HB_reset, 1'b0);
        send_fwd(16'd23, 16'd2, 16'h3000);
        send_fwd(16'd45, 16'd2, 16'h2000);
        send_fwd(16'd12, 16'd1, 16'h4000);
        wait_done(n);
        chk("lit_done_latency", n, ST + 1);
        chk("lit_ch_count_3", ch_count, 16'd3);
        tick(); tick();

        // Own and unreachable advertisements are dropped
        my_nodeID = 16'd12;
        start_round(16'd5, 16'd0);
        tick(); tick();
        send_fwd(16'd30, 16'd3, 16'h1000);
        send_adv(16'd12, 16'd1, 16'h4000);
        send_adv(16'd7, 16'hFFFF, 16'h0000);
        tick();
        chk("lit_drop_count_2", drop_count, 16'd2);
        chk("lit_fCH_kept", fCH_ID, 16'd30);
        chk("lit_no_en", en_KCH, 1'b0);

        // Window 20, advertisement accepted 18 cycles into the round
        start_round(16'd0, 16'd20);
        tick(); tick();
        repeat (18) tick();
        send_fwd(16'd61, 16'd4, 16'h2400);
        wait_done(n);
        chk("lit_window_latency", n, ST + 1);
        chk("lit_ch_count_1", ch_count, 16'd1);
        tick(); tick();

        // Heartbeat during SETTLE aborts the round
        start_round(16'd4, 16'd0);
        tick(); tick();
        send_fwd(16'd40, 16'd2, 16'h2800);
        tick();
        start_round(16'd4, 16'd0);
        chk("lit_abort_hbrst", HB_reset, 1'b1);
        chk("lit_abort_count", ch_count, 16'd0);
        chk("lit_abort_no_done", round_done, 1'b0);
        tick();

        // Limit 0 and window 0 close straight after HBRST
        start_round(16'd0, 16'd0);
        tick(); tick();
        chk("lit_empty_done", round_done, 1'b1);
        chk("lit_empty_count", ch_count, 16'd0);
        tick();
        chk("lit_empty_idle", round_active, 1'b0);

        // Reset in the middle of a round
        start_round(16'd2, 16'd0);
        tick(); tick();
        send_fwd(16'd55, 16'd1, 16'h3800);
        n = 0;
        while (!adv_ready && n < 20) begin
            tick();
            n++;
        end
        chk("lit_back_to_collect", adv_ready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_rst_fCH_Hops", fCH_Hops, 16'hFFFF);
        chk("lit_rst_fCH_ID", fCH_ID, 16'd0);
        chk("lit_rst_active", round_active, 1'b0);
        chk("lit_rst_ready", adv_ready, 1'b0);
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ch_adv_sequencer.md
# ch_adv_sequencer

Control FSM in front of the known-cluster-head (knownCH) selector of the EER-RL node. On a heartbeat it clears the selector, then accepts cluster-head advertisements one at a time over a valid/ready handshake. It drops the node's own advertisement and unreachable ones, and forwards each remaining one as a single `en_KCH` pulse with the fields held stable. The collection round closes on a CH-count limit or a cycle window.

## Interface
Parameters:
- `WORD_WIDTH`, 16: width of node ID, hop, Q-value, count and window fields.
- `SETTLE`, 2: idle cycles granted to knownCH after each `en_KCH` pulse, minimum 1.
- `HB_RST_CYC`, 2: number of cycles `HB_reset` is held high.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `my_nodeID` in WORD_WIDTH: this node's ID.
- `hb_start` in 1: heartbeat received; starts a new round.
- `hb_chlimit` in WORD_WIDTH: maximum CHs forwarded per round; 0 means unlimited. Sampled on `hb_start`.
- `hb_window` in WORD_WIDTH: round length in cycles; 0 means no timeout. Sampled on `hb_start`.
- `adv_valid` in 1 and `adv_ready` out 1: advertisement handshake.
- `adv_ID`, `adv_Hops`, `adv_QValue` in WORD_WIDTH each: advertisement payload.
- `HB_reset` out 1: drives the knownCH clear input.
- `en_KCH` out 1: knownCH update strobe.
- `fCH_ID`, `fCH_Hops`, `fCH_QValue` out WORD_WIDTH each: registered payload forwarded to knownCH.
- `round_active` out 1: high in every state except IDLE.
- `round_done` out 1: one-cycle pulse when a round closes.
- `ch_count` out WORD_WIDTH: advertisements forwarded this round.
- `drop_count` out WORD_WIDTH: advertisements dropped this round. Saturates at all ones.

## Operation
- States and transitions:
  - IDLE → HBRST on `hb_start`.
  - HBRST (`HB_reset`=1 for HB_RST_CYC cycles) → COLLECT.
  - COLLECT → ISSUE on a forwarded handshake.
  - ISSUE (`en_KCH`=1 for exactly 1 cycle) → SETTLE.
  - SETTLE (SETTLE cycles) → COLLECT or DONE.
  - DONE (`round_done`=1 for 1 cycle) → IDLE.
- Entering HBRST clears `ch_count` and `drop_count` and latches `hb_chlimit` and `hb_window`.
- `adv_ready` is 1 only in COLLECT. A handshake is `adv_valid` && `adv_ready`.
- Drop rule: `adv_ID` == `my_nodeID` or `adv_Hops` == HOPS_INVALID (all ones).
  - A dropped advertisement is consumed, `drop_count` increments, the FSM stays in COLLECT and `fCH_*` are unchanged.
- Forward rule: all other advertisements are latched into `fCH_*` and `ch_count` increments. `fCH_*` hold until the next forward or `rst`.
- Window timer:
  - Starts at 0 on entry to COLLECT from HBRST.
  - Increments every cycle in COLLECT, ISSUE and SETTLE; saturating.
  - Expires when timer+1 == latched window and the window is non-zero.
- Closure, from COLLECT: on expiry, or when the latched limit is non-zero and `ch_count` == limit → DONE.
- Closure, from SETTLE's last cycle: on the same two conditions → DONE; otherwise → COLLECT.
- Expiry during ISSUE or SETTLE does not cut the update short. The in-flight update completes, then the FSM goes to DONE.
- Latched limit = 0 and window = 0: the FSM goes HBRST → DONE directly with `ch_count`=0.
- `hb_start` in any non-IDLE state aborts the round: go to HBRST and re-latch. `round_done` is not pulsed for the aborted round.
- `hb_start` in the same cycle as DONE: the new round wins (→ HBRST) and `round_done` still pulses.
- Reset values:
  - State IDLE.
  - `fCH_Hops`=16'hFFFF.
  - All other outputs and counters 0.

## Timing
- All outputs are registered.
- `hb_start` sampled at edge 0: `HB_reset` is high for cycles 1..HB_RST_CYC, then `adv_ready` is high from cycle HB_RST_CYC+1.
- Handshake at edge t:
  - `en_KCH` and valid `fCH_*` in cycle t+1.
  - SETTLE occupies cycles t+2..t+1+SETTLE.
  - `adv_ready` returns at t+2+SETTLE unless the round closes.
- Handshake of a dropped advertisement: `adv_ready` stays high, so back-to-back drops are accepted one per cycle.
- `round_done` pulses the cycle after the closure condition. `ch_count` is final at that point and holds until the next HBRST.
- `rst` wins over every other input in the same cycle.

## Structure
- Shared package `eerrl_pkg`:
  - WORD_WIDTH.
  - HOPS_INVALID = 16'hFFFF.
  - Q-value fixed-point constant Q_ONE = 16'h4000.
  - The `ch_seq_state_t` enum (IDLE, HBRST, COLLECT, ISSUE, SETTLE, DONE).
- One sub-module, `ch_window_timer`: loadable saturating counter with clear, enable and an `expire` output, in the timer's own file.
- knownCH is instantiated beside this block, not inside it.

## Test plan
- Reset, then `hb_start` with limit 3 and window 0 → `HB_reset` high for 2 cycles, `adv_ready` high on the 3rd.
- Advertisements (23,2,16'h3000), (45,2,16'h2000), (12,1,16'h4000) → three one-cycle `en_KCH` pulses, each with `fCH_*` matching and spaced ≥SETTLE+1 cycles apart; `round_done` after the third, `ch_count`=3.
- `my_nodeID`=12, then advertisements (12,1,16'h4000) and (7,16'hFFFF,0) → no `en_KCH`, `drop_count`=2, `fCH_*` unchanged.
- Limit 0, window 20, one advertisement at cycle 18 → the update completes through SETTLE, then `round_done`, `ch_count`=1.
- `hb_start` in mid-SETTLE → HBRST re-entered, counts cleared, no `round_done` for the aborted round.
- Limit 0 and window 0 → `round_done` immediately after HBRST, `ch_count`=0; `rst` mid-COLLECT → IDLE, `fCH_Hops`=16'hFFFF.
